// File: rtl/fifo_share_arbiter.sv
// Round-robin arbiter that shares one downstream FIFO between NUM_IN AXI-stream producers.
// Each beat is tagged with its source index, producers are throttled near full, and an occupancy high-water mark is kept.
module fifo_share_arbiter #(
  parameter int NUM_IN       = 4,
  parameter int WIDTH        = 8,
  parameter int IDW          = 2,
  parameter int BURST        = 16,
  parameter int DEPTH        = 16384,
  parameter int COUNT_W      = 14,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_TDATA,
  input  logic [NUM_IN-1:0]         in_TVALID,
  output logic [NUM_IN-1:0]         in_TREADY,
  output logic [WIDTH-1:0]          fifo_TDATA,
  output logic [IDW-1:0]            fifo_TID,
  output logic                      fifo_TVALID,
  input  logic                      fifo_TREADY,
  input  logic [COUNT_W-1:0]        fifo_count,
  output logic [NUM_IN-1:0]         grant,
  output logic [COUNT_W-1:0]        hwm,
  input  logic                      hwm_clear
);

  localparam int BCW   = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int THR_I = DEPTH - AFULL_MARGIN;
  localparam logic [COUNT_W:0] THR       = THR_I[COUNT_W:0];
  localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BURST - 1);
  localparam logic [IDW-1:0]   LAST_IDX  = IDW'(NUM_IN - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_IN-1:0]   r_grant, w_grant_nxt;
  logic [IDW-1:0]      r_last, w_last_nxt, w_pick_idx;
  logic [BCW-1:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic                w_pick_found;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [IDW-1:0]      r_out_id;
  logic [COUNT_W-1:0]  r_hwm;
  logic [COUNT_W:0]    w_occ;
  logic                w_throttle, w_slot_free, w_open, w_cur_valid, w_accept;
  logic [WIDTH-1:0]    w_cur_data;

  // The held output beat counts as occupancy so the FIFO can never be overrun by it.
  assign w_occ       = {1'b0, fifo_count} + {{COUNT_W{1'b0}}, r_out_valid};
  assign w_throttle  = (w_occ >= THR);
  assign w_slot_free = ~r_out_valid | fifo_TREADY;
  assign w_open      = (r_state == S_GRANT) & w_slot_free & ~w_throttle;
  assign in_TREADY   = w_open ? r_grant : {NUM_IN{1'b0}};
  assign w_cur_valid = in_TVALID[r_last];
  assign w_cur_data  = in_TDATA[r_last*WIDTH +: WIDTH];
  assign w_accept    = w_open & w_cur_valid;

  assign fifo_TVALID = r_out_valid;
  assign fifo_TDATA  = r_out_data;
  assign fifo_TID    = r_out_id;
  assign grant       = r_grant;
  assign hwm         = r_hwm;

  // Round-robin search: scanned from farthest to nearest so the nearest valid index after r_last wins.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      w_pick_found = w_pick_found | in_TVALID[(int'(r_last) + k) % NUM_IN];
      w_pick_idx   = in_TVALID[(int'(r_last) + k) % NUM_IN] ?
                     IDW'((int'(r_last) + k) % NUM_IN) : w_pick_idx;
    end
  end

  // Grant FSM next-state: bounded bursts, idle-producer release, frozen while throttled.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found && !w_throttle) begin
          w_state_nxt             = S_GRANT;
          w_grant_nxt             = '0;
          w_grant_nxt[w_pick_idx] = 1'b1;
          w_last_nxt              = w_pick_idx;
          w_beat_cnt_nxt          = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (w_accept && (r_beat_cnt == LAST_BEAT)) begin
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = '0;
          w_beat_cnt_nxt = '0;
        end else if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + BCW'(1);
        end else if (w_slot_free && !w_throttle && !w_cur_valid) begin
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = '0;
          w_beat_cnt_nxt = '0;
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_grant_nxt    = '0;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

  // Grant FSM state registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_last     <= LAST_IDX;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_last     <= w_last_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Single output stage: loads on accept (even while draining), holds under backpressure.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_cur_data;
      r_out_id    <= r_last;
    end else if (fifo_TREADY) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Occupancy high-water mark; clear wins over update.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_hwm <= '0;
    end else if (hwm_clear) begin
      r_hwm <= '0;
    end else if (fifo_count > r_hwm) begin
      r_hwm <= fifo_count;
    end else begin
      r_hwm <= r_hwm;
    end
  end

endmodule

// File: tb/tb_fifo_share_arbiter.sv
// Randomized and directed bench for fifo_share_arbiter against a cycle-level behavioural reference model.
module tb_fifo_share_arbiter;

  localparam int NUM_IN = 4, WIDTH = 8, IDW = 2, BURST = 16;
  localparam int DEPTH = 16384, COUNT_W = 14, AFULL_MARGIN = 4;
  localparam int THR = DEPTH - AFULL_MARGIN;

  logic                    ap_clk = 1'b0;
  logic                    ap_rst_n;
  logic [NUM_IN*WIDTH-1:0] in_TDATA;
  logic [NUM_IN-1:0]       in_TVALID, in_TREADY, grant;
  logic [WIDTH-1:0]        fifo_TDATA;
  logic [IDW-1:0]          fifo_TID;
  logic                    fifo_TVALID, fifo_TREADY, hwm_clear;
  logic [COUNT_W-1:0]      fifo_count, hwm;

  fifo_share_arbiter #(
    .NUM_IN(NUM_IN), .WIDTH(WIDTH), .IDW(IDW), .BURST(BURST),
    .DEPTH(DEPTH), .COUNT_W(COUNT_W), .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
    .fifo_TDATA(fifo_TDATA), .fifo_TID(fifo_TID), .fifo_TVALID(fifo_TVALID),
    .fifo_TREADY(fifo_TREADY), .fifo_count(fifo_count),
    .grant(grant), .hwm(hwm), .hwm_clear(hwm_clear)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner is the granted producer or -1 when nobody holds the FIFO.
  int m_owner, m_last, m_burst, m_od, m_oid, m_hwm;
  bit m_ov;
  int acc_idx;
  int cyc, first_out;

  // Producers: each holds a pending queue and presents its head as a valid beat.
  int         src_q [NUM_IN][$];
  bit         p_valid [NUM_IN];
  logic [7:0] p_data [NUM_IN];
  int         out_tid_q [$];
  int         out_data_q [$];

  task automatic drive_prod();
    for (int i = 0; i < NUM_IN; i++) begin
      in_TVALID[i] = p_valid[i];
      in_TDATA[i*WIDTH +: WIDTH] = p_data[i];
    end
  endtask

  task automatic feed(input int pct);
    for (int i = 0; i < NUM_IN; i++) begin
      if (!p_valid[i] && src_q[i].size() > 0 && $urandom_range(99) < pct) begin
        p_valid[i] = 1'b1;
        p_data[i]  = 8'(src_q[i].pop_front());
      end
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = NUM_IN - 1; m_burst = 0;
    m_ov = 1'b0; m_od = 0; m_oid = 0; m_hwm = 0; acc_idx = -1;
  endtask

  // One clock: check DUT against the model, advance the model, and retire handshaken producer beats.
  task automatic step();
    int n_owner, n_last, n_burst, n_od, n_oid, n_hwm, c;
    bit n_ov, slot, thr, found;
    logic [NUM_IN-1:0] exp_rdy, exp_grant;
    drive_prod();
    #2;
    slot = !m_ov || fifo_TREADY;
    thr  = (int'(fifo_count) + int'(m_ov)) >= THR;
    exp_rdy   = '0;
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    if (m_owner >= 0 && slot && !thr) exp_rdy[m_owner] = 1'b1;
    check_eq("in_TREADY", 32'(in_TREADY), 32'(exp_rdy));
    check_eq("grant", 32'(grant), 32'(exp_grant));
    check_eq("fifo_TVALID", 32'(fifo_TVALID), 32'(m_ov));
    check_eq("fifo_TDATA", 32'(fifo_TDATA), m_od);
    check_eq("fifo_TID", 32'(fifo_TID), m_oid);
    check_eq("hwm", 32'(hwm), m_hwm);
    if (fifo_TVALID && fifo_TREADY) begin
      out_tid_q.push_back(int'(fifo_TID));
      out_data_q.push_back(int'(fifo_TDATA));
    end
    if (fifo_TVALID && first_out < 0) first_out = cyc;
    acc_idx = -1;
    if (m_owner >= 0 && exp_rdy[m_owner] && p_valid[m_owner]) acc_idx = m_owner;
    n_owner = m_owner; n_last = m_last; n_burst = m_burst;
    n_ov = m_ov; n_od = m_od; n_oid = m_oid;
    if (acc_idx >= 0) begin
      n_ov = 1'b1; n_od = int'(p_data[acc_idx]); n_oid = acc_idx;
    end else if (fifo_TREADY) begin
      n_ov = 1'b0;
    end
    if (m_owner < 0) begin
      found = 1'b0;
      if (!thr) begin
        for (int k = 1; k <= NUM_IN; k++) begin
          c = (m_last + k) % NUM_IN;
          if (!found && p_valid[c]) begin
            found = 1'b1; n_owner = c; n_last = c; n_burst = 0;
          end
        end
      end
    end else if (acc_idx >= 0) begin
      n_burst = m_burst + 1;
      if (n_burst == BURST) n_owner = -1;
    end else if (slot && !thr && !p_valid[m_owner]) begin
      n_owner = -1;
    end
    n_hwm = hwm_clear ? 0 : ((int'(fifo_count) > m_hwm) ? int'(fifo_count) : m_hwm);
    @(posedge ap_clk);
    #1;
    m_owner = n_owner; m_last = n_last; m_burst = n_burst;
    m_ov = n_ov; m_od = n_od; m_oid = n_oid; m_hwm = n_hwm;
    if (acc_idx >= 0) p_valid[acc_idx] = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    fifo_TREADY = 1'b1; fifo_count = '0; hwm_clear = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      src_q[i].delete(); p_valid[i] = 1'b0; p_data[i] = 8'h00;
    end
    drive_prod();
    model_reset();
    out_tid_q.delete(); out_data_q.delete();
    cyc = 0; first_out = -1;
    @(posedge ap_clk); #1;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_valid", 32'(fifo_TVALID), 32'h0);
    check_eq("rst_data", 32'(fifo_TDATA), 32'h0);
    check_eq("rst_tid", 32'(fifo_TID), 32'h0);
    check_eq("rst_hwm", 32'(hwm), 32'h0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
  endtask

  initial begin
    ap_rst_n = 1'b0; in_TDATA = '0; in_TVALID = '0;
    fifo_TREADY = 1'b1; fifo_count = '0; hwm_clear = 1'b0;

    // Single producer on input 1.
    do_reset();
    for (int j = 0; j < 4; j++) src_q[1].push_back(8'h10 + j);
    feed(100);
    repeat (10) begin step(); feed(100); end
    check_eq("t1_count", 32'(out_data_q.size()), 32'd4);
    for (int j = 0; j < 4 && j < out_data_q.size(); j++) begin
      check_eq("t1_data", 32'(out_data_q[j]), 32'h10 + 32'(j));
      check_eq("t1_tid", 32'(out_tid_q[j]), 32'd1);
    end
    check_eq("t1_latency", 32'(first_out), 32'd2);
    check_eq("t1_grant_end", 32'(grant), 32'h0);

    // All producers continuously valid: 16-beat bursts rotating 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NUM_IN; i++)
      for (int j = 0; j < 40; j++) src_q[i].push_back($urandom_range(255));
    feed(100);
    repeat (100) begin step(); feed(100); end
    check_eq("t2_enough", 32'(out_tid_q.size() >= 80), 32'd1);
    for (int j = 0; j < 80 && j < out_tid_q.size(); j++)
      check_eq("t2_rotation", 32'(out_tid_q[j]), 32'((j / BURST) % NUM_IN));

    // Backpressure mid-burst for 5 cycles.
    do_reset();
    for (int j = 0; j < 12; j++) src_q[2].push_back(8'h30 + j);
    feed(100);
    for (int c = 0; c < 30; c++) begin
      fifo_TREADY = !(c >= 4 && c < 9);
      step(); feed(100);
    end
    check_eq("t3_count", 32'(out_data_q.size()), 32'd12);
    for (int j = 0; j < 12 && j < out_data_q.size(); j++)
      check_eq("t3_data", 32'(out_data_q[j]), 32'h30 + 32'(j));

    // Throttle from IDLE, then release.
    do_reset();
    fifo_count = 14'(THR);
    for (int j = 0; j < 3; j++) src_q[3].push_back(8'h50 + j);
    feed(100);
    repeat (5) begin step(); feed(100); end
    check_eq("t4_idle_grant", 32'(grant), 32'h0);
    check_eq("t4_idle_rdy", 32'(in_TREADY), 32'h0);
    fifo_count = 14'(THR - 2);
    repeat (6) begin step(); feed(100); end
    check_eq("t4_resume", 32'(out_data_q.size()), 32'd3);

    // Throttle during a grant caused by the held beat (16379 + 1).
    do_reset();
    for (int j = 0; j < 8; j++) src_q[0].push_back(8'h60 + j);
    feed(100);
    step(); feed(100);
    fifo_TREADY = 1'b0;
    step(); feed(100);
    fifo_count = 14'(THR - 1);
    repeat (4) begin
      step(); feed(100);
      check_eq("t4_hold_rdy", 32'(in_TREADY), 32'h0);
      check_eq("t4_hold_grant", 32'(grant), 32'h1);
    end
    fifo_count = 14'(THR - 2); fifo_TREADY = 1'b1;
    repeat (20) begin step(); feed(100); end
    check_eq("t4_count", 32'(out_data_q.size()), 32'd8);
    for (int j = 0; j < 8 && j < out_data_q.size(); j++)
      check_eq("t4_data", 32'(out_data_q[j]), 32'h60 + 32'(j));

    // High-water mark ramp, clear, re-track.
    do_reset();
    for (int v = 0; v <= 200; v += 20) begin fifo_count = 14'(v); step(); end
    for (int v = 180; v >= 50; v -= 10) begin fifo_count = 14'(v); step(); end
    check_eq("t5_hwm_peak", 32'(hwm), 32'd200);
    hwm_clear = 1'b1; step(); hwm_clear = 1'b0;
    check_eq("t5_hwm_clear", 32'(hwm), 32'd0);
    step();
    check_eq("t5_hwm_track", 32'(hwm), 32'd50);

    // Asynchronous reset between clock edges.
    do_reset();
    for (int i = 0; i < NUM_IN; i++)
      for (int j = 0; j < 30; j++) src_q[i].push_back($urandom_range(255));
    feed(100);
    repeat (10) begin step(); feed(100); end
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_eq("t6_async_valid", 32'(fifo_TVALID), 32'h0);
    check_eq("t6_async_rdy", 32'(in_TREADY), 32'h0);
    check_eq("t6_async_grant", 32'(grant), 32'h0);
    do_reset();
    src_q[1].push_back(8'hA1); src_q[2].push_back(8'hA2);
    feed(100);
    step(); feed(100);
    check_eq("t6_first_grant", 32'(grant), 32'h2);
    repeat (8) begin step(); feed(100); end

    // Randomized traffic with backpressure, near-full occupancy, data glitches and clears.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_IN; i++)
        if (src_q[i].size() == 0) src_q[i].push_back($urandom_range(255));
      for (int i = 0; i < NUM_IN; i++)
        if (p_valid[i] && $urandom_range(15) == 0) p_data[i] = 8'($urandom_range(255));
      fifo_TREADY = ($urandom_range(3) != 0);
      fifo_count  = ($urandom_range(7) == 0) ? 14'(THR - 3 + $urandom_range(5)) : 14'($urandom_range(999));
      hwm_clear   = ($urandom_range(49) == 0);
      step();
      feed(60);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
